// File: rtl/mems_spi_master.sv
// 3-wire SPI master that shifts a 24-bit MEMS DAC command MSB-first with SYNC_n framing.
// Define MEMS_SPI_RX_EN to build the SDO readback capture path.
module mems_spi_master #(
  parameter int CLK_DIV  = 4,
  parameter int SYNC_GAP = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] data_in,
  input  logic        miso,
  output logic        busy,
  output logic        sync_n,
  output logic        sclk,
  output logic        din,
  output logic [23:0] rx_data,
  output logic        rx_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [7:0] C_HALF_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] C_GAP_LAST  = 8'(SYNC_GAP - 1);

  logic [1:0]  r_state;
  logic [7:0]  r_half_cnt;
  logic [4:0]  r_bit_cnt;
  logic [22:0] r_shift;
  logic        r_busy;
  logic        r_sync_n;
  logic        r_sclk;
  logic        r_din;
  logic        w_half_done;

  assign w_half_done = (r_half_cnt == C_HALF_LAST);

  // Bit 23 goes straight to din on load, so only the remaining 23 bits are kept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_half_cnt <= 8'd0;
      r_bit_cnt  <= 5'd0;
      r_shift    <= 23'd0;
      r_busy     <= 1'b0;
      r_sync_n   <= 1'b1;
      r_sclk     <= 1'b1;
      r_din      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_shift    <= data_in[22:0];
            r_din      <= data_in[23];
            r_busy     <= 1'b1;
            r_sync_n   <= 1'b0;
            r_sclk     <= 1'b1;
            r_half_cnt <= 8'd0;
            r_bit_cnt  <= 5'd23;
            r_state    <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (!w_half_done) begin
            r_half_cnt <= r_half_cnt + 8'd1;
          end else begin
            r_half_cnt <= 8'd0;
            if (r_sclk) begin
              r_sclk <= 1'b0;
            end else begin
              r_sclk <= 1'b1;
              if (r_bit_cnt == 5'd0) begin
                r_sync_n <= 1'b1;
                r_state  <= S_GAP;
              end else begin
                r_bit_cnt <= r_bit_cnt - 5'd1;
                r_din     <= r_shift[22];
                r_shift   <= {r_shift[21:0], 1'b0};
              end
            end
          end
        end
        S_GAP: begin
          // The half-period counter doubles as the SYNC_n gap timer.
          if (r_half_cnt == C_GAP_LAST) begin
            r_half_cnt <= 8'd0;
            r_busy     <= 1'b0;
            r_state    <= S_IDLE;
          end else begin
            r_half_cnt <= r_half_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy   = r_busy;
  assign sync_n = r_sync_n;
  assign sclk   = r_sclk;
  assign din    = r_din;

`ifdef MEMS_SPI_RX_EN
  logic [23:0] r_rx_shift;
  logic [23:0] r_rx_data;
  logic        r_rx_valid;
  logic        w_fall;
  logic        w_frame_end;

  assign w_fall      = (r_state == S_SHIFT) && w_half_done && r_sclk;
  assign w_frame_end = (r_state == S_SHIFT) && w_half_done && !r_sclk && (r_bit_cnt == 5'd0);

  // A reset-aborted frame never reaches w_frame_end, so it cannot raise rx_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_shift <= 24'd0;
      r_rx_data  <= 24'd0;
      r_rx_valid <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_fall) begin
        r_rx_shift <= {r_rx_shift[22:0], miso};
      end
      if (w_frame_end) begin
        r_rx_data  <= r_rx_shift;
        r_rx_valid <= 1'b1;
      end
    end
  end

  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;
`else
  logic w_unused_miso;

  assign w_unused_miso = miso;
  assign rx_data       = 24'd0;
  assign rx_valid      = 1'b0;
`endif

endmodule

// File: tb/tb_mems_spi_master.sv
// Self-checking bench for mems_spi_master: decodes SPI frames and compares them with the
// command words and the frame timing formulas; checks readback when MEMS_SPI_RX_EN is set.
module tb_mems_spi_master;

  localparam int CD       = 4;
  localparam int SG       = 2;
  localparam int FRAME    = 48 * CD;
  localparam int BUSY_LEN = FRAME + SG;
  localparam int BUDGET   = 2000;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] data_in;
  logic        miso;
  logic        busy;
  logic        sync_n;
  logic        sclk;
  logic        din;
  logic [23:0] rx_data;
  logic        rx_valid;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [23:0] capBits;
  int capFalls, capBusy, capSyncLow, capGapHigh, capFallErr, capDinErr;
  int capTimeout, capRxPulses, capRxCycle, capEndCycle;

  logic [23:0] rxWord = 24'd0;
  int          rxIdx  = 0;

  mems_spi_master #(.CLK_DIV(CD), .SYNC_GAP(SG)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .data_in  (data_in),
    .miso     (miso),
    .busy     (busy),
    .sync_n   (sync_n),
    .sclk     (sclk),
    .din      (din),
    .rx_data  (rx_data),
    .rx_valid (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DAC SDO model: frame start rewinds to the MSB, each SCLK fall advances one bit.
  always @(negedge sclk or negedge sync_n) begin
    if (sclk === 1'b1) rxIdx = 0;
    else rxIdx = rxIdx + 1;
  end
  assign miso = (rxIdx < 24) ? rxWord[5'(23 - rxIdx)] : 1'b0;

  task automatic launch(input logic [23:0] w);
    start   = 1'b1;
    data_in = w;
    @(negedge clk);
    start   = 1'b0;
    data_in = 24'($urandom);
  endtask

  // Records a frame from cycle 1 until busy drops, the budget runs out or the abort cycle.
  task automatic collect(input int injectCycle, input int abortCycle);
    int n;
    logic prevSclk, prevDin;
    capBits = 24'd0; capFalls = 0; capBusy = 0; capSyncLow = 0; capGapHigh = 0;
    capFallErr = 0; capDinErr = 0; capTimeout = 0; capRxPulses = 0; capRxCycle = -1;
    prevSclk = 1'b1;
    prevDin  = din;
    for (n = 1; n <= BUDGET; n++) begin
      if (n == abortCycle) begin
        rst_n = 1'b0;
        break;
      end
      if (n == injectCycle) begin
        start   = 1'b1;
        data_in = 24'hFFFFFF;
      end
      if (n == injectCycle + 1) start = 1'b0;
      if (busy !== 1'b1) break;
      capBusy++;
      if (sync_n === 1'b0) capSyncLow++;
      else capGapHigh++;
      if (prevSclk === 1'b1 && sclk === 1'b0) begin
        if (n != 1 + CD + 2 * capFalls * CD) capFallErr++;
        if (din !== prevDin) capDinErr++;
        capBits = {capBits[22:0], din};
        capFalls++;
      end
      if (rx_valid === 1'b1) begin
        capRxPulses++;
        capRxCycle = n;
      end
      prevSclk = sclk;
      prevDin  = din;
      @(negedge clk);
    end
    capEndCycle = n;
    if (n > BUDGET) capTimeout = 1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; data_in = 24'd0;
    repeat (3) @(negedge clk);
    testsRun += 6;
    if (busy !== 1'b0)      begin testsFailed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (sync_n !== 1'b1)    begin testsFailed++; $display("[TB] FAIL reset_sync_n: got %b expected 1", sync_n); end
    if (sclk !== 1'b1)      begin testsFailed++; $display("[TB] FAIL reset_sclk: got %b expected 1", sclk); end
    if (din !== 1'b0)       begin testsFailed++; $display("[TB] FAIL reset_din: got %b expected 0", din); end
    if (rx_data !== 24'd0)  begin testsFailed++; $display("[TB] FAIL reset_rx_data: got %h expected 000000", rx_data); end
    if (rx_valid !== 1'b0)  begin testsFailed++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
    rst_n = 1'b1;
    @(negedge clk);
    testsRun++;
    if ({busy, sync_n, sclk} !== 3'b011) begin
      testsFailed++; $display("[TB] FAIL post_reset_idle: got busy/sync_n/sclk %b expected 011", {busy, sync_n, sclk});
    end
  endtask

  task automatic test_idle();
    int activity = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (sclk !== 1'b1 || sync_n !== 1'b1 || busy !== 1'b0) activity++;
    end
    testsRun++;
    if (activity !== 0) begin testsFailed++; $display("[TB] FAIL idle_activity: got %0d active cycles expected 0", activity); end
  endtask

  task automatic test_single_frame(input logic [23:0] w, input logic [23:0] rw);
    rxWord = rw;
    @(negedge clk);
    launch(w);
    collect(0, 0);
    testsRun += 8;
    if (capTimeout !== 0)      begin testsFailed++; $display("[TB] FAIL frame_timeout: busy still high after %0d cycles", BUDGET); end
    if (capFalls !== 24)       begin testsFailed++; $display("[TB] FAIL frame_falls: got %0d expected 24", capFalls); end
    if (capBits !== w)         begin testsFailed++; $display("[TB] FAIL frame_bits: got %h expected %h", capBits, w); end
    if (capBusy !== BUSY_LEN)  begin testsFailed++; $display("[TB] FAIL frame_busy_len: got %0d expected %0d", capBusy, BUSY_LEN); end
    if (capSyncLow !== FRAME)  begin testsFailed++; $display("[TB] FAIL frame_sync_low: got %0d expected %0d", capSyncLow, FRAME); end
    if (capGapHigh !== SG)     begin testsFailed++; $display("[TB] FAIL frame_gap: got %0d expected %0d", capGapHigh, SG); end
    if (capFallErr !== 0)      begin testsFailed++; $display("[TB] FAIL frame_fall_timing: got %0d misplaced falls expected 0", capFallErr); end
    if (capDinErr !== 0)       begin testsFailed++; $display("[TB] FAIL frame_din_stable: got %0d din changes at falls expected 0", capDinErr); end
`ifdef MEMS_SPI_RX_EN
    testsRun += 3;
    if (capRxPulses !== 1)       begin testsFailed++; $display("[TB] FAIL rx_pulses: got %0d expected 1", capRxPulses); end
    if (capRxCycle !== FRAME+1)  begin testsFailed++; $display("[TB] FAIL rx_cycle: got %0d expected %0d", capRxCycle, FRAME + 1); end
    if (rx_data !== rw)          begin testsFailed++; $display("[TB] FAIL rx_data: got %h expected %h", rx_data, rw); end
`else
    testsRun += 2;
    if (capRxPulses !== 0)   begin testsFailed++; $display("[TB] FAIL rx_pulses: got %0d expected 0", capRxPulses); end
    if (rx_data !== 24'd0)   begin testsFailed++; $display("[TB] FAIL rx_data: got %h expected 000000", rx_data); end
`endif
  endtask

  task automatic test_back_to_back();
    logic [23:0] w1, w2;
    w1 = 24'($urandom);
    w2 = 24'($urandom);
    @(negedge clk);
    launch(w1);
    collect(0, 0);
    testsRun += 3;
    if (capBits !== w1)              begin testsFailed++; $display("[TB] FAIL b2b_first_bits: got %h expected %h", capBits, w1); end
    if (capEndCycle !== BUSY_LEN+1)  begin testsFailed++; $display("[TB] FAIL b2b_first_idle_cycle: got %0d expected %0d", capEndCycle, BUSY_LEN + 1); end
    if (capGapHigh !== SG)           begin testsFailed++; $display("[TB] FAIL b2b_gap: got %0d expected %0d", capGapHigh, SG); end
    launch(w2);
    testsRun++;
    if ({busy, sync_n} !== 2'b10) begin
      testsFailed++; $display("[TB] FAIL b2b_second_start: got busy/sync_n %b expected 10", {busy, sync_n});
    end
    collect(0, 0);
    testsRun += 2;
    if (capBits !== w2)          begin testsFailed++; $display("[TB] FAIL b2b_second_bits: got %h expected %h", capBits, w2); end
    if (capBusy !== BUSY_LEN)    begin testsFailed++; $display("[TB] FAIL b2b_second_busy: got %0d expected %0d", capBusy, BUSY_LEN); end
  endtask

  task automatic test_ignored_start();
    logic [23:0] w;
    int extra = 0;
    w = 24'h3C5A01 ^ 24'($urandom_range(0, 255));
    @(negedge clk);
    launch(w);
    collect(50, 0);
    testsRun += 2;
    if (capBits !== w)        begin testsFailed++; $display("[TB] FAIL ignored_bits: got %h expected %h", capBits, w); end
    if (capBusy !== BUSY_LEN) begin testsFailed++; $display("[TB] FAIL ignored_busy: got %0d expected %0d", capBusy, BUSY_LEN); end
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (busy !== 1'b0 || sync_n !== 1'b1) extra++;
    end
    testsRun++;
    if (extra !== 0) begin testsFailed++; $display("[TB] FAIL ignored_no_second_frame: got %0d active cycles expected 0", extra); end
  endtask

  task automatic test_reset_midframe();
    logic [23:0] w2;
    w2 = 24'($urandom);
    @(negedge clk);
    launch(24'($urandom));
    collect(0, 70);
    #1;
    testsRun += 2;
    if ({busy, sync_n, sclk} !== 3'b011) begin
      testsFailed++; $display("[TB] FAIL abort_outputs: got busy/sync_n/sclk %b expected 011", {busy, sync_n, sclk});
    end
    if (capRxPulses !== 0 || rx_valid !== 1'b0) begin
      testsFailed++; $display("[TB] FAIL abort_rx_valid: got %0d pulses expected 0", capRxPulses + int'(rx_valid));
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    launch(w2);
    collect(0, 0);
    testsRun += 3;
    if (capFalls !== 24)      begin testsFailed++; $display("[TB] FAIL abort_recover_falls: got %0d expected 24", capFalls); end
    if (capBits !== w2)       begin testsFailed++; $display("[TB] FAIL abort_recover_bits: got %h expected %h", capBits, w2); end
    if (capBusy !== BUSY_LEN) begin testsFailed++; $display("[TB] FAIL abort_recover_busy: got %0d expected %0d", capBusy, BUSY_LEN); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; data_in = 24'd0;
    test_reset();
    test_idle();
    test_single_frame(24'h3F0080, 24'hA5C3E7);
    for (int i = 0; i < 3; i++) test_single_frame(24'($urandom), 24'($urandom));
    test_single_frame(24'hFFFFFF, 24'h000001);
    test_back_to_back();
    test_ignored_start();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
